// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Y86 fetch stage. Walks a byte-wide instruction memory with a req/ack
//   handshake, assembles 1/2/5/6-byte instructions (little-endian valC),
//   predicts the next PC (jXX/call predicted taken) and offers each complete
//   instruction on the f_* bundle until the decode register consumes it.
//   Redirects (mispredict / ret) override everything in the same cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   D_stall_i           decode register stalled: offered instruction not taken
//   redirect_i          load redirect_pc_i as the new fetch PC this cycle
//   redirect_pc_i       redirect target
//   imem_req_o          byte read request, held until imem_ack_i
//   imem_addr_o         byte address of the request
//   imem_ack_i          read complete, imem_data_i valid (ignored without req)
//   imem_data_i         returned byte
//   f_valid_o           complete instruction offered on f_*
//   f_icode_o/f_ifun_o  opcode fields
//   f_rA_o/f_rB_o       register specifiers (RNONE when absent)
//   f_dstE_o/f_dstM_o   destination registers for E and M results
//   f_valC_o            constant word (0 when absent)
//   f_valP_o            address of the next sequential instruction
//   f_ierr_o            offered instruction has an invalid icode
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [7:0]  imem_data_i,
    output logic        f_valid_o,
    output logic [3:0]  f_icode_o,
    output logic [3:0]  f_ifun_o,
    output logic [3:0]  f_rA_o,
    output logic [3:0]  f_rB_o,
    output logic [3:0]  f_dstE_o,
    output logic [3:0]  f_dstM_o,
    output logic [31:0] f_valC_o,
    output logic [31:0] f_valP_o,
    output logic        f_ierr_o
);

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] INOP   = 4'h1;
    localparam logic [3:0] RESP   = 4'h4;
    localparam logic       ENABLE = 1'b1;

    typedef enum logic [2:0] {
        S_OP,
        S_REG,
        S_CONST,
        S_HOLD,
        S_HALTED
    } state_t;

    // -------------------------------------------------------------------------
    // Instruction-format helpers
    // -------------------------------------------------------------------------
    function automatic logic has_reg(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:                                  has_reg = 1'b0;
        endcase
    endfunction

    function automatic logic has_const(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
            default:                      has_const = 1'b0;
        endcase
    endfunction

    // Invalid icodes fall into the default and are treated as 1-byte.
    function automatic logic [2:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 3'd2;
            4'h7, 4'h8:             instr_len = 3'd5;
            4'h3, 4'h4, 4'h5:       instr_len = 3'd6;
            default:                instr_len = 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] dst_e(input logic [3:0] ic, input logic [3:0] rb);
        case (ic)
            4'h2, 4'h3, 4'h6:       dst_e = rb;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RESP;
            default:                dst_e = RNONE;
        endcase
    endfunction

    function automatic logic [3:0] dst_m(input logic [3:0] ic, input logic [3:0] ra);
        case (ic)
            4'h5, 4'hB: dst_m = ra;
            default:    dst_m = RNONE;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [2:0]  off_q;      // bytes of the current instruction already fetched
    logic [1:0]  cnt_q;      // valC byte index while in S_CONST

    // Partially assembled instruction; only meaningful between OP ack and HOLD
    logic [3:0]  cur_icode, cur_ifun, cur_ra, cur_rb;
    logic [31:0] cur_valc;
    logic [3:0]  asm_icode_d, asm_ifun_d, asm_ra_d, asm_rb_d;
    logic [31:0] asm_valc_d;

    logic ack;
    logic consume;
    logic enter_hold;

    // Request is masked while rst is high even though the state already reads OP.
    assign imem_req_o  = !rst && (state_q == S_OP || state_q == S_REG || state_q == S_CONST);
    assign imem_addr_o = pc_q + {29'b0, off_q};
    assign ack         = imem_ack_i && imem_req_o;
    assign consume     = (state_q == S_HOLD) && (D_stall_i != ENABLE);
    assign f_valid_o   = (state_q == S_HOLD);

    // -------------------------------------------------------------------------
    // Byte assembly: merge the byte being acked into the instruction
    // -------------------------------------------------------------------------
    always_comb begin
        asm_icode_d = cur_icode;
        asm_ifun_d  = cur_ifun;
        asm_ra_d    = cur_ra;
        asm_rb_d    = cur_rb;
        asm_valc_d  = cur_valc;
        case (state_q)
            S_OP: begin
                asm_icode_d = imem_data_i[7:4];
                asm_ifun_d  = imem_data_i[3:0];
                asm_ra_d    = RNONE;
                asm_rb_d    = RNONE;
                asm_valc_d  = '0;
            end
            S_REG: begin
                asm_ra_d = imem_data_i[7:4];
                asm_rb_d = imem_data_i[3:0];
            end
            S_CONST: begin
                asm_valc_d[{cnt_q, 3'b000} +: 8] = imem_data_i;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic; redirect overrides every other transition
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OP: begin
                if (ack) begin
                    if (has_reg(asm_icode_d))        state_d = S_REG;
                    else if (has_const(asm_icode_d)) state_d = S_CONST;
                    else                             state_d = S_HOLD;
                end
            end
            S_REG: begin
                if (ack) state_d = has_const(asm_icode_d) ? S_CONST : S_HOLD;
            end
            S_CONST: begin
                if (ack && cnt_q == 2'd3) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (consume) state_d = (f_icode_o == 4'h0) ? S_HALTED : S_OP;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_OP;
        endcase
        if (redirect_i) state_d = S_OP;
    end

    assign enter_hold = ack && !redirect_i && (state_d == S_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_OP;
        else     state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // PC and byte counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            off_q <= '0;
            cnt_q <= '0;
        end else if (redirect_i) begin
            pc_q  <= redirect_pc_i;
            off_q <= '0;
            cnt_q <= '0;
        end else if (consume) begin
            // jXX and call are predicted taken
            pc_q  <= (f_icode_o == 4'h7 || f_icode_o == 4'h8) ? f_valC_o : f_valP_o;
            off_q <= '0;
            cnt_q <= '0;
        end else if (ack) begin
            off_q <= off_q + 3'd1;
            if (state_q == S_CONST) cnt_q <= cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (ack && !redirect_i) begin
            cur_icode <= asm_icode_d;
            cur_ifun  <= asm_ifun_d;
            cur_ra    <= asm_ra_d;
            cur_rb    <= asm_rb_d;
            cur_valc  <= asm_valc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Offered bundle: loaded only when the last byte lands
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_icode_o <= INOP;
            f_ifun_o  <= 4'h0;
            f_rA_o    <= RNONE;
            f_rB_o    <= RNONE;
            f_dstE_o  <= RNONE;
            f_dstM_o  <= RNONE;
            f_valC_o  <= '0;
            f_valP_o  <= '0;
            f_ierr_o  <= 1'b0;
        end else if (enter_hold) begin
            f_icode_o <= asm_icode_d;
            f_ifun_o  <= asm_ifun_d;
            f_rA_o    <= asm_ra_d;
            f_rB_o    <= asm_rb_d;
            f_dstE_o  <= dst_e(asm_icode_d, asm_rb_d);
            f_dstM_o  <= dst_m(asm_icode_d, asm_ra_d);
            f_valC_o  <= asm_valc_d;
            f_valP_o  <= pc_q + {29'b0, instr_len(asm_icode_d)};
            f_ierr_o  <= (asm_icode_d > 4'hB);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        D_stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [7:0]  imem_data_i;
    logic        f_valid_o;
    logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o;
    logic [31:0] f_valC_o, f_valP_o;
    logic        f_ierr_o;

    logic        ack_en;
    logic [7:0]  mem [0:511];
    int          n_tests;
    int          n_fail;

    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk           (clk),
        .rst           (rst),
        .D_stall_i     (D_stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .f_valid_o     (f_valid_o),
        .f_icode_o     (f_icode_o),
        .f_ifun_o      (f_ifun_o),
        .f_rA_o        (f_rA_o),
        .f_rB_o        (f_rB_o),
        .f_dstE_o      (f_dstE_o),
        .f_dstM_o      (f_dstM_o),
        .f_valC_o      (f_valC_o),
        .f_valP_o      (f_valP_o),
        .f_ierr_o      (f_ierr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: acks in the same cycle as the request when enabled.
    assign imem_ack_i  = imem_req_o && ack_en;
    assign imem_data_i = mem[imem_addr_o[8:0]];

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        @(negedge clk);
        redirect_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; D_stall_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ack_en = 1'b0;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({imem_req_o, f_valid_o, f_ierr_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: req/valid/ierr=%b expected 000", {imem_req_o, f_valid_o, f_ierr_o});
        end
        n_tests++;
        if ({f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o} !== 24'h10FFFF) begin
            n_fail++; $display("FAIL reset_fields: got %h expected 10ffff", {f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o});
        end
        n_tests++;
        if ({f_valC_o, f_valP_o} !== 64'h0) begin
            n_fail++; $display("FAIL reset_words: valC=%h valP=%h expected 0", f_valC_o, f_valP_o);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            n_fail++; $display("FAIL reset_first_req: req=%b addr=%h expected 1 00000100", imem_req_o, imem_addr_o);
        end
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        n_tests++;
        if ({f_valid_o, f_icode_o, f_dstE_o, f_dstM_o} !== 13'h11FF || f_valP_o !== 32'h101) begin
            n_fail++; $display("FAIL reset_nop: valid=%b icode=%h dstE=%h dstM=%h valP=%h expected 1 1 f f 00000101",
                               f_valid_o, f_icode_o, f_dstE_o, f_dstM_o, f_valP_o);
        end
    endtask

    task automatic test_irmovl();
        redirect_to(32'h0);
        ack_en = 1'b1;
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL irmovl_req: req=%b addr=%h expected 1 00000000", imem_req_o, imem_addr_o);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (f_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL irmovl_early: valid=%b after 5 cycles expected 0", f_valid_o);
        end
        @(negedge clk);
        ack_en = 1'b0;
        n_tests++;
        if (f_valid_o !== 1'b1 || f_icode_o !== 4'h3 || f_rA_o !== 4'hF || f_rB_o !== 4'h3) begin
            n_fail++; $display("FAIL irmovl_fields: valid=%b icode=%h rA=%h rB=%h expected 1 3 f 3",
                               f_valid_o, f_icode_o, f_rA_o, f_rB_o);
        end
        n_tests++;
        if (f_valC_o !== 32'h12345678 || f_valP_o !== 32'h6 || f_dstE_o !== 4'h3 || f_dstM_o !== 4'hF) begin
            n_fail++; $display("FAIL irmovl_words: valC=%h valP=%h dstE=%h dstM=%h expected 12345678 00000006 3 f",
                               f_valC_o, f_valP_o, f_dstE_o, f_dstM_o);
        end
    endtask

    task automatic test_jxx();
        redirect_to(32'h20);
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
        ack_en = 1'b0;
        n_tests++;
        if (f_valid_o !== 1'b1 || f_valC_o !== 32'h100 || f_valP_o !== 32'h25 || f_rA_o !== 4'hF) begin
            n_fail++; $display("FAIL jxx_fields: valid=%b valC=%h valP=%h rA=%h expected 1 00000100 00000025 f",
                               f_valid_o, f_valC_o, f_valP_o, f_rA_o);
        end
        D_stall_i = 1'b0;
        @(negedge clk);
        D_stall_i = 1'b1;
        n_tests++;
        if (f_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            n_fail++; $display("FAIL jxx_predict: valid=%b req=%b addr=%h expected 0 1 00000100",
                               f_valid_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_stall();
        redirect_to(32'h30);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({f_valid_o, imem_req_o, f_icode_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o} !== 22'h2B0F40 ||
                f_valP_o !== 32'h32) begin
                n_fail++; $display("FAIL stall_hold[%0d]: valid=%b req=%b icode=%h rA=%h rB=%h dstE=%h dstM=%h valP=%h expected 1 0 b 0 f 4 0 00000032",
                                   i, f_valid_o, imem_req_o, f_icode_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o, f_valP_o);
            end
            @(negedge clk);
        end
        D_stall_i = 1'b0;
        @(negedge clk);
        D_stall_i = 1'b1;
        n_tests++;
        if (f_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h32) begin
            n_fail++; $display("FAIL stall_release: valid=%b req=%b addr=%h expected 0 1 00000032",
                               f_valid_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect_const();
        redirect_to(32'h0);
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (imem_addr_o !== 32'h4 || f_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_const_addr: addr=%h valid=%b expected 00000004 0", imem_addr_o, f_valid_o);
        end
        redirect_to(32'h40);
        ack_en = 1'b0;
        n_tests++;
        if (f_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL redir_const_next: valid=%b req=%b addr=%h expected 0 1 00000040",
                               f_valid_o, imem_req_o, imem_addr_o);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (f_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL redir_const_hold: valid=%b req=%b addr=%h expected 0 1 00000040",
                               f_valid_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_halt_ierr();
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        n_tests++;
        if (f_valid_o !== 1'b1 || f_icode_o !== 4'h0 || f_valP_o !== 32'h41) begin
            n_fail++; $display("FAIL halt_offer: valid=%b icode=%h valP=%h expected 1 0 00000041",
                               f_valid_o, f_icode_o, f_valP_o);
        end
        ack_en = 1'b1;
        D_stall_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (imem_req_o !== 1'b0 || f_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL halted[%0d]: req=%b valid=%b expected 0 0", i, imem_req_o, f_valid_o);
            end
            @(negedge clk);
        end
        ack_en = 1'b0;
        D_stall_i = 1'b1;
        redirect_to(32'h0);
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL halt_resume: req=%b addr=%h expected 1 00000000", imem_req_o, imem_addr_o);
        end
        redirect_to(32'h50);
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        n_tests++;
        if ({f_valid_o, f_ierr_o, f_icode_o, f_ifun_o, f_rA_o} !== 14'h3C5F || f_valP_o !== 32'h51 || f_valC_o !== 32'h0) begin
            n_fail++; $display("FAIL ierr_offer: valid=%b ierr=%b icode=%h ifun=%h rA=%h valP=%h valC=%h expected 1 1 c 5 f 00000051 00000000",
                               f_valid_o, f_ierr_o, f_icode_o, f_ifun_o, f_rA_o, f_valP_o, f_valC_o);
        end
        D_stall_i = 1'b0;
        @(negedge clk);
        D_stall_i = 1'b1;
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h51) begin
            n_fail++; $display("FAIL ierr_next: req=%b addr=%h expected 1 00000051", imem_req_o, imem_addr_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h10;
        // irmovl $0x12345678, %ebx
        mem[9'h000] = 8'h30; mem[9'h001] = 8'hF3; mem[9'h002] = 8'h78;
        mem[9'h003] = 8'h56; mem[9'h004] = 8'h34; mem[9'h005] = 8'h12;
        // jmp 0x100
        mem[9'h020] = 8'h70; mem[9'h021] = 8'h00; mem[9'h022] = 8'h01;
        mem[9'h023] = 8'h00; mem[9'h024] = 8'h00;
        // popl %eax
        mem[9'h030] = 8'hB0; mem[9'h031] = 8'h0F;
        // halt
        mem[9'h040] = 8'h00;
        // invalid icode C
        mem[9'h050] = 8'hC5;

        test_reset();
        test_irmovl();
        test_jxx();
        test_stall();
        test_redirect_const();
        test_halt_ierr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Y86 fetch stage that produces the `f_*` bundle latched by the decode pipeline register. It walks a byte-wide instruction-memory port with a req/ack handshake and assembles 1-, 2-, 5- or 6-byte instructions, little-endian `valC`. It predicts the next PC and holds each complete instruction until the decode register accepts it. It also accepts redirects for branch mispredicts and `ret`.

## Interface
- `RESET_PC`, default 32'h0: PC loaded at reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `D_stall_i`  in  1  decode register holding (`ENABLE` = stalled); the offered instruction is not consumed.
- `redirect_i`  in  1  pipeline redirect (mispredict or ret) this cycle.
- `redirect_pc_i`  in  `WORD`  new fetch PC when `redirect_i`.
- `imem_req_o`  out  1  byte read request; held until ack.
- `imem_addr_o`  out  `WORD`  byte address of the request.
- `imem_ack_i`  in  1  read complete; `imem_data_i` valid this cycle; ignored unless `imem_req_o`.
- `imem_data_i`  in  8  returned byte.
- `f_valid_o`  out  1  complete instruction offered on `f_*`; when 0, pipeline control must drive `D_bubble_i`.
- `f_icode_o`, `f_ifun_o`, `f_rA_o`, `f_rB_o`, `f_dstE_o`, `f_dstM_o`  out  `NIBBLE`  instruction fields.
- `f_valC_o`, `f_valP_o`  out  `WORD`  constant word and address of the next sequential instruction.
- `f_ierr_o`  out  1  offered instruction has an invalid icode (>4'hB).

## Operation
- The FSM has five states: OP (fetch the icode:ifun byte), REG (fetch the rA:rB byte), CONST (fetch 4 valC bytes, counter 0..3, byte k → valC[8k+7:8k]), HOLD (`f_valid_o`=1), HALTED.
- `imem_req_o`=1 exactly in OP/REG/CONST; `imem_addr_o` = PC + bytes fetched so far for this instruction (32-bit wrap).
- Instruction lengths:
  - 1 byte: 0 halt, 1 nop, 9 ret, invalid icodes.
  - 2 bytes: 2 rrmovl, 6 OPl, A pushl, B popl.
  - 5 bytes: 7 jXX, 8 call; the icode byte is followed directly by valC.
  - 6 bytes: 3 irmovl, 4 rmmovl, 5 mrmovl.
- OP ack: latch icode/ifun. Go to REG if the instruction has a register byte, to CONST if it is jXX/call, else to HOLD.
- REG ack → CONST for icode 3/4/5, else HOLD. CONST ack with counter=3 → HOLD.
- Fields not fetched: rA/rB = `RNONE`, valC = 0.
- valP = PC + length.
- dstE = rB for icodes 2/3/6; 4'h4 (%esp) for 8/9/A/B; else `RNONE`.
- dstM = rA for icodes 5/B; else `RNONE`.
- Consumption: in HOLD with `D_stall_i`≠`ENABLE`. At that edge, PC ← valC for jXX/call, else valP. Next state is HALTED if icode=0, else OP.
- HALTED: no requests, `f_valid_o`=0; leaves only on redirect.
- `f_ierr_o` is set for icode >B; the instruction is still offered, with length 1.

## Timing
- Reset (async) sets:
  - State OP, PC = `RESET_PC`, `imem_req_o`=0 while `rst` is high.
  - `f_valid_o`=0, `f_ierr_o`=0, `f_icode_o`=`INOP`, `f_ifun_o`=0.
  - rA/rB/dstE/dstM = `RNONE`, valC/valP = 0.
- Latency: with ack in the same cycle as each req, an n-byte instruction gives `f_valid_o`=1 n cycles after the first req. The next req follows in the cycle after consumption.
- One request outstanding at a time; req and addr are stable until ack.
- `f_*` outputs change only on entry to HOLD, and are stable while in HOLD.
- Redirect has priority over everything, including consumption and an ack in the same cycle. At that edge: PC ← `redirect_pc_i`, state OP, byte counter cleared, `f_valid_o` ← 0. The ack is discarded.
- Redirect in HALTED restarts fetch.
- `rst` mid-fetch aborts immediately; no partial instruction is ever offered.

## Test plan
- Reset with `RESET_PC`=0x100, memory holding `10` (nop) → first req addr 0x100; after ack, `f_valid_o`=1, icode 1, valP 0x101, dstE/dstM=F.
- irmovl 0x12345678,%ebx: bytes 30 F3 78 56 34 12 at 0x0, ack every cycle → valid on cycle 6; rA=F, rB=3, valC=0x12345678, valP=6, dstE=3.
- jXX at 0x20 with bytes 70 00 01 00 00, no stall → next req addr 0x100.
- `D_stall_i` held 3 cycles in HOLD on popl %eax (B0 0F) → outputs stable and no new req. Release → consumed; dstE=4, dstM=0.
- Redirect to 0x40 in CONST byte 2, with a simultaneous ack → ack discarded, `f_valid_o`=0, next req addr 0x40.
- halt (00) consumed → HALTED with no reqs for 10 cycles; redirect to 0x0 resumes at 0x0. Icode 0xC → `f_ierr_o`=1, valP=PC+1.
